pixel_serializer: RTL



---
 rtl/pixel_pkg.sv | 25 ++
 rtl/pixel_serializer_lane_next_sel.sv | 34 +++
 rtl/pixel_serializer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel serializer slice: state encoding,
// the coordinate value driven while no beat is active, and default widths.
package pixel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OUT   = 2'd1,
        EMPTY = 2'd2
    } state_t;

    localparam int IDLE_COORD = 1;

    localparam int DEF_LANES = 4;
    localparam int DEF_CW    = 24;
    localparam int DEF_XW    = 10;
    localparam int DEF_YW    = 10;
    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;

    // Width of a lane index; a single-lane build still needs one bit.
    function automatic int cur_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/pixel_serializer_lane_next_sel.sv
// lane_next_sel: priority encoder over a lane mask. Reports the lowest set
// lane, the lowest set lane strictly above cur, and whether cur is the
// highest set lane (no set lane above it).
module lane_next_sel #(
    parameter int LANES = 4,
    parameter int CURW  = 2
) (
    input  logic [LANES-1:0] mask,
    input  logic [CURW-1:0]  cur,
    output logic [CURW-1:0]  first_idx,
    output logic [CURW-1:0]  next_idx,
    output logic             is_last
);

    logic has_next;

    // Scan from the top lane down so the lowest matching lane wins.
    always_comb begin
        first_idx = '0;
        next_idx  = '0;
        has_next  = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first_idx = CURW'(i);
            end
            if (mask[i] && (i > int'(cur))) begin
                next_idx = CURW'(i);
                has_next = 1'b1;
            end
        end
        is_last = !has_next;
    end

endmodule

// File: rtl/pixel_serializer.sv
// pixel_serializer: captures a batch of LANES pixels in one cycle and drains
// the valid lanes one per accepted beat (WEN/ready) in ascending lane order.
// Optional build macro PIXEL_SERIALIZER_CLIP_EN drops lanes whose coordinates
// fall outside H_RES x V_RES at capture time.
module pixel_serializer
    import pixel_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int CW    = DEF_CW,
    parameter int XW    = DEF_XW,
    parameter int YW    = DEF_YW,
    parameter int H_RES = DEF_H_RES,
    parameter int V_RES = DEF_V_RES
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                store,
    output logic                store_ready,
    input  logic [LANES-1:0]    lane_valid,
    input  logic [LANES*CW-1:0] rgb_in,
    input  logic [LANES*XW-1:0] x_in,
    input  logic [LANES*YW-1:0] y_in,
    input  logic                ready,
    output logic                WEN,
    output logic [CW-1:0]       rgb_out,
    output logic [XW-1:0]       x_coord,
    output logic [YW-1:0]       y_coord,
    output logic                done,
    output logic                busy
);

    localparam int CURW = cur_width(LANES);

    state_t           state;
    logic [LANES-1:0] mask_q;
    logic [CURW-1:0]  cur_q;
    logic [CW-1:0]    rgb_bank [LANES];
    logic [XW-1:0]    x_bank   [LANES];
    logic [YW-1:0]    y_bank   [LANES];

    logic [LANES-1:0] cap_mask;
    logic             capture;
    logic [CURW-1:0]  cur_next;
    logic             cur_is_last;
    logic [CURW-1:0]  cap_first;
    logic [CURW-1:0]  held_first_unused;
    logic [CURW-1:0]  cap_next_unused;
    logic             cap_last_unused;

`ifdef PIXEL_SERIALIZER_CLIP_EN
    // Lanes landing outside the visible frame are removed from the batch here.
    always_comb begin
        cap_mask = lane_valid;
        for (int i = 0; i < LANES; i++) begin
            if ((int'(x_in[i*XW +: XW]) >= H_RES) || (int'(y_in[i*YW +: YW]) >= V_RES)) begin
                cap_mask[i] = 1'b0;
            end
        end
    end
`else
    localparam int clip_bounds_unused = H_RES + V_RES;
    assign cap_mask = lane_valid;
`endif

    // Walk of the held batch: where to go after the current lane.
    lane_next_sel #(.LANES(LANES), .CURW(CURW)) u_sel_held (
        .mask      (mask_q),
        .cur       (cur_q),
        .first_idx (held_first_unused),
        .next_idx  (cur_next),
        .is_last   (cur_is_last)
    );

    // Entry point of the incoming batch, needed on the capture edge itself.
    lane_next_sel #(.LANES(LANES), .CURW(CURW)) u_sel_cap (
        .mask      (cap_mask),
        .cur       ('0),
        .first_idx (cap_first),
        .next_idx  (cap_next_unused),
        .is_last   (cap_last_unused)
    );

    assign store_ready = (state == IDLE) || (state == EMPTY) ||
                         ((state == OUT) && ready && cur_is_last);
    assign capture     = store && store_ready;

    // Batch capture and lane sequencing; a new batch can load on the final beat.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state  <= IDLE;
            mask_q <= '0;
            cur_q  <= '0;
        end else if (capture) begin
            mask_q <= cap_mask;
            for (int i = 0; i < LANES; i++) begin
                rgb_bank[i] <= rgb_in[i*CW +: CW];
                x_bank[i]   <= x_in[i*XW +: XW];
                y_bank[i]   <= y_in[i*YW +: YW];
            end
            if (cap_mask != '0) begin
                state <= OUT;
                cur_q <= cap_first;
            end else begin
                state <= EMPTY;
                cur_q <= '0;
            end
        end else begin
            case (state)
                IDLE:  state <= IDLE;
                EMPTY: state <= IDLE;
                OUT: begin
                    if (ready) begin
                        if (cur_is_last) begin
                            state <= IDLE;
                        end else begin
                            cur_q <= cur_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign WEN     = (state == OUT);
    assign rgb_out = (state == OUT) ? rgb_bank[cur_q] : '0;
    assign x_coord = (state == OUT) ? x_bank[cur_q] : XW'(IDLE_COORD);
    assign y_coord = (state == OUT) ? y_bank[cur_q] : YW'(IDLE_COORD);
    assign done    = ((state == OUT) && ready && cur_is_last) || (state == EMPTY);
    assign busy    = (state != IDLE);

endmodule
